// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the async FIFO write port among N_REQ requesters, winner locked per burst.
// Latency: 1 cycle IDLE->LOCK arbitration, then winc/wdata combinational with the accepted beat (0 cycles).
// Backpressure: wfull drops gnt/winc for the owner and holds the beat count; non-owners wait for their turn.
module fifo_wr_arbiter #(
    parameter int N_REQ     = 4,
    parameter int DSIZE     = 8,
    parameter int MAX_BURST = 4,
    localparam int PW       = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    localparam int BW       = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1
) (
    input  logic                   wclk,
    input  logic                   wrst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ-1:0]       last,
    input  logic [N_REQ*DSIZE-1:0] din,
    input  logic                   wfull,
    output logic [N_REQ-1:0]       gnt,
    output logic                   winc,
    output logic [DSIZE-1:0]       wdata,
    output logic [PW-1:0]          owner,
    output logic                   busy
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_LOCK = 1'b1;

    logic [0:0]       state_q,    state_d;
    logic [PW-1:0]    rr_ptr_q,   rr_ptr_d;
    logic [PW-1:0]    owner_q,    owner_d;
    logic [BW-1:0]    beat_cnt_q, beat_cnt_d;

    logic             pick_vld;
    logic [PW-1:0]    pick_idx;
    logic             owner_req;
    logic             owner_last;
    logic [DSIZE-1:0] owner_dat;
    logic             beat_acc;
    logic             cap_hit;
    logic [PW-1:0]    owner_nxt;

    // Round-robin search: first requesting index starting at rr_ptr, wrapping explicitly at N_REQ.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            int cand;
            cand = int'(rr_ptr_q) + k;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            if (req[cand]) begin
                pick_vld = 1'b1;
                pick_idx = PW'(cand);
            end
        end
    end

    // Select the locked requester's request, last flag and data slice.
    always_comb begin
        owner_req  = 1'b0;
        owner_last = 1'b0;
        owner_dat  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (owner_q == PW'(i)) begin
                owner_req  = req[i];
                owner_last = last[i];
                owner_dat  = din[i*DSIZE +: DSIZE];
            end
        end
    end

    assign beat_acc  = (state_q == ST_LOCK) && owner_req && !wfull;
    assign cap_hit   = (beat_cnt_q == BW'(MAX_BURST - 1));
    assign owner_nxt = (owner_q == PW'(N_REQ - 1)) ? '0 : owner_q + PW'(1);

    // Grant, write strobe and data: only the owner may write, and never into a full FIFO.
    always_comb begin
        gnt = '0;
        for (int i = 0; i < N_REQ; i++) begin
            gnt[i] = (state_q == ST_LOCK) && (owner_q == PW'(i)) && !wfull;
        end
        winc  = beat_acc;
        wdata = beat_acc ? owner_dat : '0;
    end

    // Next-state: arbitrate in IDLE, count beats in LOCK, release on last or burst cap.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        beat_cnt_d = beat_cnt_q;
        if (state_q == ST_IDLE) begin
            if (pick_vld) begin
                state_d    = ST_LOCK;
                owner_d    = pick_idx;
                beat_cnt_d = '0;
            end
        end else if (beat_acc) begin
            beat_cnt_d = beat_cnt_q + BW'(1);
            if (owner_last || cap_hit) begin
                state_d  = ST_IDLE;
                rr_ptr_d = owner_nxt;
            end
        end
    end

    // State registers; reset aborts any partial burst.
    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign owner = owner_q;
    assign busy  = (state_q == ST_LOCK);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized bench for fifo_wr_arbiter with a cycle-level reference model and per-requester data scoreboard.
// Stimulus pushes expected outputs per cycle; a negedge monitor pops and compares.
// Requesters hold beats until the model grants them, so lost or duplicated data shows up as a data miscompare.
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int MB = 4;

    logic            wclk = 1'b0;
    logic            wrst;
    logic [N-1:0]    req;
    logic [N-1:0]    last;
    logic [N*DW-1:0] din;
    logic            wfull;
    logic [N-1:0]    gnt;
    logic            winc;
    logic [DW-1:0]   wdata;
    logic [1:0]      owner;
    logic            busy;

    fifo_wr_arbiter #(.N_REQ(N), .DSIZE(DW), .MAX_BURST(MB)) dut (
        .wclk(wclk), .wrst(wrst), .req(req), .last(last), .din(din), .wfull(wfull),
        .gnt(gnt), .winc(winc), .wdata(wdata), .owner(owner), .busy(busy)
    );

    always #5 wclk = ~wclk;

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Source beats {last, data}; data = {requester id, sequence number}.
    logic [DW:0]   src_q[N][$];
    logic [DW-1:0] exp_data[N][$];
    int            seq[N];

    task automatic push_chunk(input int i, input int len);
        logic [3:0]    id;
        logic [11:0]   sn;
        logic [DW-1:0] d;
        id = 4'(i);
        for (int b = 0; b < len; b++) begin
            sn = 12'(seq[i]);
            d  = {id, sn};
            seq[i]++;
            src_q[i].push_back({(b == len - 1), d});
            exp_data[i].push_back(d);
        end
    endtask

    // Reference model: who holds the port, beats taken in this burst, who has top priority next.
    bit m_busy;
    int m_owner;
    int m_ptr;
    int m_cnt;

    typedef struct packed {
        logic [N-1:0]  gnt;
        logic          winc;
        logic [DW-1:0] wdata;
        logic          busy;
        logic [1:0]    owner;
    } exp_t;
    exp_t exp_q[$];

    int p_req;
    int p_full;

    // Apply the inputs the DUT has just sampled on this edge.
    task automatic advance();
        logic [DW:0] beat;
        if (!m_busy) begin
            if (req != '0) begin
                for (int k = N - 1; k >= 0; k--) begin
                    if (req[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
                end
                m_busy = 1'b1;
                m_cnt  = 0;
            end
        end else if (!wfull && req[m_owner]) begin
            beat = src_q[m_owner].pop_front();
            m_cnt++;
            if (beat[DW] || m_cnt == MB) begin
                m_busy = 1'b0;
                m_ptr  = (m_owner + 1) % N;
            end
        end
    endtask

    task automatic gen_inputs();
        logic [DW:0] head;
        wfull = ($urandom_range(99) < p_full);
        for (int i = 0; i < N; i++) begin
            if (src_q[i].size() > 0 && $urandom_range(99) < p_req) begin
                head              = src_q[i][0];
                req[i]            = 1'b1;
                last[i]           = head[DW];
                din[i*DW +: DW]   = head[DW-1:0];
            end else begin
                req[i]            = 1'b0;
                last[i]           = 1'($urandom_range(1));
                din[i*DW +: DW]   = DW'($urandom);
            end
        end
    endtask

    task automatic push_expected();
        exp_t e;
        logic acc;
        acc     = m_busy && !wfull && req[m_owner];
        e.busy  = m_busy;
        e.owner = 2'(m_owner);
        e.gnt   = (m_busy && !wfull) ? N'(1 << m_owner) : '0;
        e.winc  = acc;
        e.wdata = acc ? din[m_owner*DW +: DW] : '0;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge wclk);
        #1;
        advance();
        gen_inputs();
        push_expected();
    endtask

    function automatic bit work_left();
        bit w;
        w = m_busy;
        for (int i = 0; i < N; i++) if (src_q[i].size() > 0) w = 1'b1;
        return w;
    endfunction

    task automatic drain(input string name, input int budget);
        int c;
        c = 0;
        while (work_left() && c < budget) begin
            step();
            c++;
        end
        chk(name, 32'(c < budget), 32'd1);
    endtask

    // Reset asserted mid-cycle while every requester is asking; outputs must clear at once.
    task automatic reset_mid();
        @(posedge wclk);
        #1;
        advance();
        wfull = 1'b0;
        for (int i = 0; i < N; i++) begin
            req[i]          = 1'b1;
            last[i]         = 1'b0;
            din[i*DW +: DW] = src_q[i][0][DW-1:0];
        end
        #2 wrst = 1'b1;
        #1;
        chk("rst_mid_gnt",   32'(gnt),   32'd0);
        chk("rst_mid_winc",  32'(winc),  32'd0);
        chk("rst_mid_busy",  32'(busy),  32'd0);
        chk("rst_mid_wdata", 32'(wdata), 32'd0);
        @(posedge wclk);
        #1;
        wrst    = 1'b0;
        m_busy  = 1'b0;
        m_ptr   = 0;
        m_cnt   = 0;
        m_owner = 0;
        chk("rst_mid_owner", 32'(owner), 32'd0);
    endtask

    // Monitor: per-cycle output compare plus per-requester data order on each write.
    exp_t          mon_e;
    logic [3:0]    mon_id;
    logic [DW-1:0] mon_exp;
    always @(negedge wclk) begin
        if (!wrst) begin
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                chk("gnt",   32'(gnt),   32'(mon_e.gnt));
                chk("winc",  32'(winc),  32'(mon_e.winc));
                chk("wdata", 32'(wdata), 32'(mon_e.wdata));
                chk("busy",  32'(busy),  32'(mon_e.busy));
                if (mon_e.busy) chk("owner", 32'(owner), 32'(mon_e.owner));
            end
            if (winc) begin
                chk("write_when_full", 32'(wfull), 32'd0);
                mon_id = wdata[DW-1:DW-4];
                if (mon_id < 4'(N) && exp_data[mon_id].size() > 0) begin
                    mon_exp = exp_data[mon_id].pop_front();
                    chk("data_order", 32'(wdata), 32'(mon_exp));
                end else begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_write: got 0x%0h expected no write at %0t", wdata, $time);
                end
            end
        end
    end

    initial begin
        int remaining;
        int len;
        wrst    = 1'b1;
        req     = '0;
        last    = '0;
        din     = '0;
        wfull   = 1'b0;
        m_busy  = 1'b0;
        m_owner = 0;
        m_ptr   = 0;
        m_cnt   = 0;
        for (int i = 0; i < N; i++) seq[i] = 0;
        #1;
        chk("rst_gnt",   32'(gnt),   32'd0);
        chk("rst_winc",  32'(winc),  32'd0);
        chk("rst_busy",  32'(busy),  32'd0);
        chk("rst_owner", 32'(owner), 32'd0);
        chk("rst_wdata", 32'(wdata), 32'd0);
        repeat (2) @(posedge wclk);
        #1 wrst = 1'b0;

        // Round-robin between 0 and 2, single-beat bursts.
        p_req  = 100;
        p_full = 0;
        for (int r = 0; r < 6; r++) begin
            push_chunk(0, 1);
            push_chunk(2, 1);
        end
        drain("drain_rr", 200);

        // Burst cap: 6-beat burst on 0 split by a pending requester 1.
        push_chunk(0, 6);
        push_chunk(1, 2);
        drain("drain_cap", 200);

        // Full stalls and requester gaps.
        p_req  = 60;
        p_full = 40;
        for (int i = 0; i < N; i++) begin
            for (int c = 0; c < 5; c++) push_chunk(i, $urandom_range(1, 7));
        end
        drain("drain_stall", 2000);

        // Reset in the middle of a burst.
        p_req  = 100;
        p_full = 0;
        for (int i = 0; i < N; i++) push_chunk(i, 6);
        repeat (3) step();
        reset_mid();
        drain("drain_reset", 500);

        // End-to-end: 1000 beats per requester with random full.
        p_req  = 80;
        p_full = 30;
        for (int i = 0; i < N; i++) begin
            remaining = 1000;
            while (remaining > 0) begin
                len = $urandom_range(1, 7);
                if (len > remaining) len = remaining;
                push_chunk(i, len);
                remaining -= len;
            end
        end
        drain("drain_e2e", 60000);

        @(negedge wclk);
        #1;
        for (int i = 0; i < N; i++) chk("data_left", 32'(exp_data[i].size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
